serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around the team's single-bit adder cell. The block accepts two WIDTH-bit operands and a carry-in, and adds one bit per clock, LSB first. A single carry flip-flop closes the loop, and the result is presented as a registered WIDTH-bit sum plus carry-out. It sits directly upstream of the half_adder cells, feeding them one operand bit pair per cycle and consuming their SUM/CARRY outputs. It is the area-minimal alternative to a parallel ripple adder.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

- CLK  in  1  rising-edge clock; only clock in the block.
- RST  in  1  synchronous, active-high reset, sampled on CLK rising edge.
- START  in  1  request to begin an addition; sampled only when BUSY=0.
- A  in  WIDTH  operand A; captured on the edge that accepts START.
- B  in  WIDTH  operand B; captured on the edge that accepts START.
- CIN  in  1  carry-in; captured with A/B.
- BUSY  out  1  high while bits are being processed.
- DONE  out  1  one-cycle pulse; SUM/COUT are newly valid.
- SUM  out  WIDTH  registered result (A+B+CIN) mod 2^WIDTH.
- COUT  out  1  registered carry-out of bit WIDTH-1.

## Operation
- Datapath per bit: s = a0 ^ b0 ^ c; c_next = (a0 & b0) | (c & (a0 ^ b0)). Implement as two half_adder instances plus an OR gate.
- Internal state:
  - operand shift registers SA and SB (WIDTH bits each);
  - partial-sum shift register PS (WIDTH bits);
  - carry flop C;
  - bit counter CNT, width $clog2(WIDTH)+1;
  - result registers SUM and COUT.
- FSM states: IDLE, RUN, FIN.
  - IDLE: BUSY=0, DONE=0. START=1 → load SA=A, SB=B, C=CIN, CNT=0, PS=0; go to RUN.
  - RUN: BUSY=1. Each edge: PS = {s, PS[WIDTH-1:1]}; SA, SB shift right by 1 (zero fill); C = c_next; CNT += 1.
    - When CNT = WIDTH-1 on this edge: SUM = {s, PS[WIDTH-1:1]}, COUT = c_next; go to FIN.
  - FIN: DONE=1, BUSY=0. START=1 → accepted exactly as in IDLE, go to RUN. Otherwise go to IDLE.
- START while BUSY=1 is ignored; the in-flight operation and its operands are unaffected.
- SUM/COUT change only on the completion edge. They hold the previous result during RUN, and hold indefinitely until the next completion.
- A, B and CIN are don't-care except on the edge that accepts START.
- Full-range arithmetic: 0 ≤ A+B+CIN ≤ 2^(WIDTH+1)-1, with {COUT,SUM} equal to the exact sum. No overflow flag.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0. SA, SB, PS, C and CNT are cleared.
- RST has priority over everything.
  - RST asserted mid-RUN aborts the operation: no DONE pulse, and SUM/COUT are cleared to 0 on the reset edge.
  - START coincident with RST is dropped.
- Let E0 be the edge that accepts START.
  - BUSY=1 after E0.
  - Bit k is processed on edge E(k+1).
  - After edge E(WIDTH): DONE=1, BUSY=0, SUM/COUT valid.
  - After E(WIDTH+1): DONE=0, unless a new result completes.
- Latency is WIDTH cycles from START acceptance to DONE.
- Back-to-back throughput: one result per WIDTH+1 cycles (START held high continuously).
- WIDTH=1: RUN lasts one edge; DONE follows on the next cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold RST 3 cycles with START=1 and random A/B → BUSY=0, DONE=0, SUM=0, COUT=0 throughout and one cycle after release.
- Basic add (WIDTH=8): A=0x5A, B=0x3C, CIN=0, START pulse at E0 → BUSY high E0..E8, DONE high only after E8, SUM=0x96, COUT=0.
- Full carry chain: A=0xFF, B=0x01, CIN=0 → SUM=0x00, COUT=1. Then A=0xFF, B=0xFF, CIN=1 → SUM=0xFF, COUT=1.
- Ignored START: accept A=0x10, B=0x20, then at E3 drive START=1 with A=0xAA, B=0x55 → single DONE at E8, SUM=0x30, COUT=0.
- Abort: accept A=0x81, B=0x81, assert RST at E4 → BUSY=0, SUM=0, COUT=0, and no DONE in the following 10 cycles.
- Back-to-back: START held high with A=0x01, B=0x01, then A=0x80, B=0x80 → DONE after E8 (SUM=0x02, COUT=0) and after E17 (SUM=0x00, COUT=1). The first DONE cycle accepts the second operation.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first, through
// two half-adder cells and a single carry flop. Result is held until the next completion.

module half_adder (
  input  logic A,
  input  logic B,
  output logic SUM,
  output logic CARRY
);
  assign SUM   = A ^ B;
  assign CARRY = A & B;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, ps;
  logic             c;
  logic [CW-1:0]    cnt;

  logic p, g, s, t, c_next;
  logic [WIDTH-1:0] ps_next;

  half_adder u_ha0 (.A(sa[0]), .B(sb[0]), .SUM(p), .CARRY(g));
  half_adder u_ha1 (.A(p),     .B(c),     .SUM(s), .CARRY(t));
  assign c_next = g | t;

  // New bit enters at the MSB; written as shifts so WIDTH=1 needs no special case.
  assign ps_next = (ps >> 1) | ({{(WIDTH-1){1'b0}}, s} << (WIDTH-1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      SUM   <= '0;
      COUT  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            sa    <= A;
            sb    <= B;
            c     <= CIN;
            cnt   <= '0;
            ps    <= '0;
            state <= RUN;
            BUSY  <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
          DONE <= 1'b0;
        end
        RUN: begin
          ps  <= ps_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= c_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            SUM   <= ps_next;
            COUT  <= c_next;
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed scenarios plus random operands, checked
// against an arithmetic model of the sum and the cycle-level BUSY/DONE timing.

module tb_serial_adder;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, START, CIN;
  logic [W-1:0] A, B;
  logic         BUSY, DONE, COUT;
  logic [W-1:0] SUM;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, ".sum"},  SUM,  exp_sum);
    chk({tag, ".cout"}, COUT, exp_cout);
  endtask

  // Full operation from idle: accept, W busy cycles, one DONE cycle, then idle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci);
    logic [W:0] full;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    START = 1'b1; A = a; B = b; CIN = ci;
    tick;
    START = 1'b0; A = $urandom; B = $urandom; CIN = $urandom;
    for (int k = 1; k < W; k++) begin
      chk({tag, ".busy"}, BUSY, 1'b1);
      chk({tag, ".done_early"}, DONE, 1'b0);
      chk_result({tag, ".hold"});
      tick;
    end
    chk({tag, ".busy_last"}, BUSY, 1'b1);
    tick;
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    chk({tag, ".done"}, DONE, 1'b1);
    chk({tag, ".busy_fin"}, BUSY, 1'b0);
    chk_result(tag);
    tick;
    chk({tag, ".done_clr"}, DONE, 1'b0);
    chk_result({tag, ".after"});
  endtask

  initial begin
    logic [W:0] full;
    RST = 1'b1; START = 1'b0; A = '0; B = '0; CIN = 1'b0;

    // Reset held with START asserted.
    START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = $urandom; B = $urandom; CIN = $urandom;
      tick;
      chk("rst.busy", BUSY, 1'b0);
      chk("rst.done", DONE, 1'b0);
      chk_result("rst");
    end
    RST = 1'b0; START = 1'b0;
    tick;
    chk("rst_rel.busy", BUSY, 1'b0);
    chk("rst_rel.done", DONE, 1'b0);
    chk_result("rst_rel");

    run_op("basic", 8'h5A, 8'h3C, 1'b0);
    run_op("chain1", 8'hFF, 8'h01, 1'b0);
    run_op("chain2", 8'hFF, 8'hFF, 1'b1);

    // START during RUN must be ignored.
    START = 1'b1; A = 8'h10; B = 8'h20; CIN = 1'b0;
    tick;
    START = 1'b0;
    for (int e = 1; e <= W; e++) begin
      if (e == 3) begin START = 1'b1; A = 8'hAA; B = 8'h55; CIN = 1'b1; end
      tick;
      START = 1'b0;
      if (e < W) chk("ign.nodone", DONE, 1'b0);
    end
    exp_sum = 8'h30; exp_cout = 1'b0;
    chk("ign.done", DONE, 1'b1);
    chk_result("ign");
    tick;
    chk("ign.single", DONE, 1'b0);
    chk("ign.idle", BUSY, 1'b0);

    // Abort by reset mid-operation.
    START = 1'b1; A = 8'h81; B = 8'h81; CIN = 1'b0;
    tick;
    START = 1'b0;
    for (int e = 1; e < 4; e++) tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
    chk("abort.busy", BUSY, 1'b0);
    chk_result("abort");
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("abort.nodone", DONE, 1'b0);
    end
    chk_result("abort.hold");

    // Back-to-back with START held high.
    START = 1'b1; A = 8'h01; B = 8'h01; CIN = 1'b0;
    tick;
    A = 8'h80; B = 8'h80;
    for (int e = 1; e < W; e++) begin
      tick;
      chk("b2b1.busy", BUSY, e < W ? 1'b1 : 1'b0);
    end
    tick;
    exp_sum = 8'h02; exp_cout = 1'b0;
    chk("b2b1.done", DONE, 1'b1);
    chk_result("b2b1");
    tick;
    A = $urandom; B = $urandom;
    chk("b2b2.busy", BUSY, 1'b1);
    chk("b2b2.done_clr", DONE, 1'b0);
    for (int e = 1; e < W; e++) begin
      tick;
      chk("b2b2.nodone", DONE, 1'b0);
    end
    tick;
    START = 1'b0;
    exp_sum = 8'h00; exp_cout = 1'b1;
    chk("b2b2.done", DONE, 1'b1);
    chk_result("b2b2");
    tick;
    chk("b2b2.done_clr2", DONE, 1'b0);
    chk("b2b2.idle", BUSY, 1'b0);

    // Random operands with random idle gaps.
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = $urandom; rb = $urandom; rc = $urandom;
      run_op("rand", ra, rb, rc);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      chk("rand.model", {COUT, SUM}, full);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        A = $urandom; B = $urandom; CIN = $urandom;
        tick;
        chk("rand.gap_busy", BUSY, 1'b0);
        chk_result("rand.gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
